// File: rtl/key_irq_ctrl_if.sv
// CPU peripheral bus seen by the key controller: address, write data, write strobe and read data.
interface key_irq_ctrl_if;
  logic [31:0] addr;
  logic [31:0] datain;
  logic        We;
  logic [31:0] dataout;

  modport master (output addr, output datain, output We, input dataout);
  modport slave  (input addr, input datain, input We, output dataout);
endinterface

// File: rtl/key_irq_ctrl.sv
// Eight-key controller: synchronise, debounce, latch press events into PEND, gate with MASK, raise irq.
// Optional KEY_RELEASE_IRQ_EN also latches release events into PEND[15:8] and enables MASK[15:8].
module key_irq_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  key_irq_ctrl_if.slave bus,
  input  logic [7:0]    user_key,
  output logic          irq
);

  localparam logic [31:0]      ADDR_KEY  = 32'h0000_7f34;
  localparam logic [31:0]      ADDR_PEND = 32'h0000_7f38;
  localparam logic [31:0]      ADDR_MASK = 32'h0000_7f3c;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0]       key_norm;
  logic [7:0]       sync_1;
  logic [7:0]       sync;
  logic [7:0]       stable;
  logic [7:0]       accept;
  logic [CNT_W-1:0] cnt [8];
  logic [7:0]       pend_press;
  logic [7:0]       pend_rel;
  logic [7:0]       mask_lo;
  logic [7:0]       mask_hi;
  logic             wr_pend;
  logic             wr_mask;

  // Normalising before the synchroniser makes the reset value 0 equal the released level.
  assign key_norm = KEY_ACTIVE_LOW ? ~user_key : user_key;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_1 <= '0;
      sync   <= '0;
    end else begin
      sync_1 <= key_norm;
      sync   <= sync_1;
    end
  end

  always_comb begin
    accept = '0;
    for (int i = 0; i < 8; i++) begin
      accept[i] = (sync[i] != stable[i]) && (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable <= '0;
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (sync[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          cnt[i]    <= '0;
          stable[i] <= sync[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign wr_pend = bus.We && (bus.addr == ADDR_PEND);
  assign wr_mask = bus.We && (bus.addr == ADDR_MASK);

  // New events are OR-ed in after the W1C so a coincident set wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_press <= '0;
      mask_lo    <= '0;
    end else begin
      pend_press <= (pend_press & ~(wr_pend ? bus.datain[7:0] : 8'h00)) | (accept & sync);
      if (wr_mask) mask_lo <= bus.datain[7:0];
    end
  end

`ifdef KEY_RELEASE_IRQ_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_rel <= '0;
      mask_hi  <= '0;
    end else begin
      pend_rel <= (pend_rel & ~(wr_pend ? bus.datain[15:8] : 8'h00)) | (accept & ~sync);
      if (wr_mask) mask_hi <= bus.datain[15:8];
    end
  end

  logic unused_datain;
  assign unused_datain = ^bus.datain[31:16];
`else
  assign pend_rel = '0;
  assign mask_hi  = '0;

  logic unused_datain;
  assign unused_datain = ^bus.datain[31:8];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) irq <= 1'b0;
    else        irq <= |({pend_rel, pend_press} & {mask_hi, mask_lo});
  end

  always_comb begin
    bus.dataout = '0;
    case (bus.addr)
      ADDR_KEY:  bus.dataout = {24'b0, stable};
      ADDR_PEND: bus.dataout = {16'b0, pend_rel, pend_press};
      ADDR_MASK: bus.dataout = {16'b0, mask_hi, mask_lo};
      default:   bus.dataout = '0;
    endcase
  end

endmodule

// File: tb/tb_key_irq_ctrl.sv
// Directed bench for key_irq_ctrl with a 4-cycle debounce and active-low keys.
module tb_key_irq_ctrl;

  localparam logic [31:0] A_KEY  = 32'h0000_7f34;
  localparam logic [31:0] A_PEND = 32'h0000_7f38;
  localparam logic [31:0] A_MASK = 32'h0000_7f3c;
  localparam logic [31:0] A_BAD  = 32'h0000_7f40;

`ifdef KEY_RELEASE_IRQ_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] user_key;
  logic       irq;
  int         checks;
  int         failures;

  key_irq_ctrl_if bus ();

  key_irq_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (4),
    .KEY_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .user_key (user_key),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.addr = a;
    #1;
    chk(tag, bus.dataout, exp);
  endtask

  // Called at a falling edge; the write lands on the following rising edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.addr   = a;
    bus.datain = d;
    bus.We     = 1'b1;
    @(negedge clk);
    bus.We     = 1'b0;
    bus.datain = '0;
    bus.addr   = A_KEY;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b0;
    user_key   = 8'hff;
    bus.addr   = A_KEY;
    bus.datain = '0;
    bus.We     = 1'b0;

    #1;
    chk("reset_irq", {31'b0, irq}, 32'h0);
    rd("reset_key", A_KEY, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Clean press of key 2 with mask bit 2 set.
    wr(A_MASK, 32'h0000_0004);
    rd("mask_rd", A_MASK, 32'h0000_0004);
    user_key = 8'hfb;
    repeat (5) @(negedge clk);
    rd("press_key_early", A_KEY, 32'h0);
    rd("press_pend_early", A_PEND, 32'h0);
    @(negedge clk);
    rd("press_key", A_KEY, 32'h04);
    rd("press_pend", A_PEND, 32'h04);
    chk("press_irq_lag", {31'b0, irq}, 32'h0);
    @(negedge clk);
    chk("press_irq", {31'b0, irq}, 32'h1);
    user_key = 8'hff;
    repeat (8) @(negedge clk);
    rd("release_key", A_KEY, 32'h0);
    rd("release_pend", A_PEND, REL ? 32'h0404 : 32'h0004);

    // W1C clear drops irq one edge after the PEND update.
    wr(A_PEND, 32'h0000_0404);
    rd("clr_pend", A_PEND, 32'h0);
    chk("clr_irq_lag", {31'b0, irq}, 32'h1);
    @(negedge clk);
    chk("clr_irq", {31'b0, irq}, 32'h0);

    // Three-cycle glitch on key 5 is rejected.
    user_key = 8'hdf;
    repeat (3) @(negedge clk);
    user_key = 8'hff;
    repeat (8) @(negedge clk);
    rd("glitch_key", A_KEY, 32'h0);
    rd("glitch_pend", A_PEND, 32'h0);
    chk("glitch_irq", {31'b0, irq}, 32'h0);

    // Four-cycle press on key 5 is accepted; mask bit 5 is off.
    user_key = 8'hdf;
    repeat (4) @(negedge clk);
    user_key = 8'hff;
    @(negedge clk);
    rd("press4_key_early", A_KEY, 32'h0);
    @(negedge clk);
    rd("press4_key", A_KEY, 32'h20);
    repeat (6) @(negedge clk);
    rd("press4_key_rel", A_KEY, 32'h0);
    rd("press4_pend", A_PEND, REL ? 32'h2020 : 32'h0020);
    chk("unmasked_irq", {31'b0, irq}, 32'h0);

    // Setting the mask later raises irq one edge after the write.
    wr(A_MASK, 32'h0000_0024);
    chk("mask_irq_lag", {31'b0, irq}, 32'h0);
    @(negedge clk);
    chk("mask_irq", {31'b0, irq}, 32'h1);

    // Writes with We low and to unmapped addresses are ignored.
    bus.addr   = A_MASK;
    bus.datain = 32'h0000_ffff;
    @(negedge clk);
    bus.datain = '0;
    rd("we0_mask", A_MASK, 32'h0000_0024);
    wr(A_BAD, 32'hffff_ffff);
    rd("bad_rd", A_BAD, 32'h0);
    rd("bad_wr_mask", A_MASK, 32'h0000_0024);
    rd("bad_wr_pend", A_PEND, REL ? 32'h2020 : 32'h0020);

    wr(A_PEND, 32'h0000_ffff);
    wr(A_MASK, 32'h0000_0100);
    rd("mask_hi", A_MASK, REL ? 32'h0000_0100 : 32'h0);
    @(negedge clk);
    chk("idle_irq", {31'b0, irq}, 32'h0);

    // Key 0 accept edge coincides with a PEND write of bit 0: the set wins.
    user_key = 8'hfe;
    repeat (5) @(negedge clk);
    rd("coinc_pend_early", A_PEND, 32'h0);
    bus.addr   = A_PEND;
    bus.datain = 32'h0000_0001;
    bus.We     = 1'b1;
    @(negedge clk);
    bus.We     = 1'b0;
    bus.datain = '0;
    rd("coinc_pend", A_PEND, 32'h0001);
    rd("coinc_key", A_KEY, 32'h01);
    @(negedge clk);
    chk("coinc_irq", {31'b0, irq}, 32'h0);

    // Release of key 0 with only mask bit 8 set.
    user_key = 8'hff;
    repeat (5) @(negedge clk);
    rd("rel_pend_early", A_PEND, 32'h0001);
    @(negedge clk);
    rd("rel_pend", A_PEND, REL ? 32'h0101 : 32'h0001);
    rd("rel_key", A_KEY, 32'h0);
    @(negedge clk);
    chk("rel_irq", {31'b0, irq}, REL ? 32'h1 : 32'h0);

    wr(A_MASK, 32'h0000_0101);
    @(negedge clk);
    chk("pre_reset_irq", {31'b0, irq}, 32'h1);

    // Asynchronous reset mid-cycle clears everything before any edge.
    #3;
    reset = 1'b0;
    #1;
    chk("async_irq", {31'b0, irq}, 32'h0);
    rd("async_pend", A_PEND, 32'h0);
    rd("async_mask", A_MASK, 32'h0);
    rd("async_key", A_KEY, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
